sdram_bank_arb: RTL and testbench

//  Round-robin arbiter sharing one bank port (rden/wren/addr/valid/fetch/wr_data) of the 8-bit slot-based SDRAM controller among NCLI clients.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/sdram_bank_arb_rr_arbiter.sv | 34 +++
 rtl/sdram_bank_arb.sv | 182 ++++++++++++++++++
 tb/tb_sdram_bank_arb.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM bank-port arbiter: FSM state encoding and client limit.
package sdram_arb_pkg;

    localparam int MAX_CLI = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/sdram_bank_arb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int c;

    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        // Scan from farthest to nearest so the nearest requester is written last and wins.
        for (int k = N - 1; k >= 0; k--) begin
            c = int'(ptr_i) + k;
            if (c >= N) c = c - N;
            if (req_i[c]) begin
                gnt_o    = '0;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_bank_arb.sv
// Round-robin arbiter serialising whole read/write transactions from NCLI clients onto one SDRAM bank port.
module sdram_bank_arb
    import sdram_arb_pkg::*;
#(
    parameter int NCLI      = 3,
    parameter int AW        = 32,
    parameter int BURST_LEN = 2,
    parameter int WR_HOLD   = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ram_rdy_n,
    input  logic [NCLI-1:0]      cli_req,
    input  logic [NCLI-1:0]      cli_we,
    input  logic [NCLI*AW-1:0]   cli_addr,
    input  logic [NCLI*8-1:0]    cli_wdata,
    output logic [NCLI-1:0]      cli_rvalid,
    output logic [7:0]           cli_rdata,
    output logic [NCLI-1:0]      cli_done,
    output logic                 rden,
    output logic                 wren,
    output logic [AW-1:0]        addr,
    output logic [7:0]           wr_data,
    input  logic                 valid,
    input  logic                 fetch,
    input  logic [7:0]           rd_data
);

    localparam int IW = $clog2(NCLI);
    localparam int CW = $clog2(BURST_LEN) + 1;
    localparam int HW = $clog2(WR_HOLD) + 1;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NCLI-1:0] owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rden_q, rden_d;
    logic            wren_q, wren_d;
    logic [NCLI-1:0] rvalid_q, rvalid_d;
    logic [NCLI-1:0] done_q, done_d;

    logic [NCLI-1:0] gnt;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_any;
    logic [AW-1:0]   sel_addr;
    logic [7:0]      sel_wdata;
    logic            sel_we;
    logic            grant_ok;

    rr_arbiter #(
        .N  (NCLI),
        .IW (IW)
    ) u_rr (
        .req_i (cli_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NCLI; i++) begin
            if (gnt[i]) begin
                sel_addr  = cli_addr[i*AW +: AW];
                sel_wdata = cli_wdata[i*8 +: 8];
            end
        end
        sel_we = |(cli_we & gnt);
    end

    // The done cycle is excluded so the finishing client can drop its level request before the next pick.
    assign grant_ok = !ram_rdy_n && gnt_any && (done_q == '0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rdata_d   = rdata_q;
        rden_d    = rden_q;
        wren_d    = wren_q;
        rvalid_d  = '0;
        done_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    owner_d = gnt;
                    ptr_d   = (gnt_idx == IW'(NCLI - 1)) ? '0 : gnt_idx + 1'b1;
                    cnt_d   = '0;
                    addr_d  = sel_addr;
                    if (sel_we) begin
                        wren_d    = 1'b1;
                        wr_data_d = sel_wdata;
                        state_d   = ST_WR;
                    end else begin
                        rden_d  = 1'b1;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (valid) begin
                    rdata_d  = rd_data;
                    rvalid_d = owner_q;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CW'(BURST_LEN - 1)) begin
                        rden_d  = 1'b0;
                        done_d  = owner_q;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR: begin
                if (fetch) begin
                    wren_d  = 1'b0;
                    hold_d  = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == HW'(WR_HOLD - 1)) begin
                    done_d    = owner_q;
                    wr_data_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            rdata_q   <= '0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            rvalid_q  <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            rdata_q   <= rdata_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            rvalid_q  <= rvalid_d;
            done_q    <= done_d;
        end
    end

    assign rden       = rden_q;
    assign wren       = wren_q;
    assign addr       = addr_q;
    assign wr_data    = wr_data_q;
    assign cli_rdata  = rdata_q;
    assign cli_rvalid = rvalid_q;
    assign cli_done   = done_q;

endmodule

// File: tb/tb_sdram_bank_arb.sv
// Randomised transaction-level bench for sdram_bank_arb with a round-robin owner model and a bank-port responder.
module tb_sdram_bank_arb;

    localparam int NCLI = 3;
    localparam int AW   = 32;
    localparam int BL   = 2;
    localparam int WH   = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 ram_rdy_n;
    logic [NCLI-1:0]      cli_req;
    logic [NCLI-1:0]      cli_we;
    logic [NCLI*AW-1:0]   cli_addr;
    logic [NCLI*8-1:0]    cli_wdata;
    logic [NCLI-1:0]      cli_rvalid;
    logic [7:0]           cli_rdata;
    logic [NCLI-1:0]      cli_done;
    logic                 rden;
    logic                 wren;
    logic [AW-1:0]        addr;
    logic [7:0]           wr_data;
    logic                 valid;
    logic                 fetch;
    logic [7:0]           rd_data;

    logic [AW-1:0] c_addr  [NCLI];
    logic          c_we    [NCLI];
    logic [7:0]    c_wdata [NCLI];

    int total = 0;
    int bad   = 0;
    int model_ptr = 0;
    int mode = 0;
    int order_q[$];
    logic [7:0] rd_q[$];

    sdram_bank_arb #(
        .NCLI(NCLI), .AW(AW), .BURST_LEN(BL), .WR_HOLD(WH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ram_rdy_n(ram_rdy_n),
        .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
        .cli_rvalid(cli_rvalid), .cli_rdata(cli_rdata), .cli_done(cli_done),
        .rden(rden), .wren(wren), .addr(addr), .wr_data(wr_data),
        .valid(valid), .fetch(fetch), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        cli_addr  = '0;
        cli_wdata = '0;
        cli_we    = '0;
        for (int i = 0; i < NCLI; i++) begin
            cli_addr[i*AW +: AW] = c_addr[i];
            cli_wdata[i*8 +: 8]  = c_wdata[i];
            cli_we[i]            = c_we[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic arm(input int i, input bit we);
        c_addr[i]  = ($urandom & 32'h00FF_FFFF) | (32'(i) << 24);
        c_we[i]    = we;
        c_wdata[i] = 8'($urandom);
        cli_req[i] = 1'b1;
    endtask

    // Reference owner choice: first requester at or after the pointer, modulo NCLI.
    function automatic int model_pick();
        for (int k = 0; k < NCLI; k++) begin
            if (cli_req[(model_ptr + k) % NCLI]) return (model_ptr + k) % NCLI;
        end
        return -1;
    endfunction

    task automatic run_one(input bit drop_mid, input bit rdy_mid);
        int pick;
        int waited;
        int sent;
        bit exp_rv;
        bit finished;
        logic [7:0] exp_byte;
        logic [NCLI-1:0] oh;
        pick = model_pick();
        check("has_req", pick >= 0, 1);
        if (pick < 0) return;
        oh = NCLI'(1) << pick;

        waited = 0;
        while (!(rden || wren) && waited < 40) begin
            check("idle_rvalid", cli_rvalid, 0);
            check("idle_done", cli_done, 0);
            check("idle_wdata", wr_data, 0);
            valid   = ($urandom_range(0, 3) == 0);
            fetch   = ($urandom_range(0, 3) == 0);
            rd_data = 8'($urandom);
            @(negedge clk);
            waited++;
        end
        valid = 1'b0;
        fetch = 1'b0;
        check("start", rden || wren, 1);
        if (!(rden || wren)) return;
        order_q.push_back(pick);
        model_ptr = (pick + 1) % NCLI;
        check("addr", addr, c_addr[pick]);
        check("is_wr", wren, c_we[pick]);
        check("is_rd", rden, !c_we[pick]);

        if (!c_we[pick]) begin
            sent = 0; exp_rv = 0; finished = 0; exp_byte = '0;
            for (int cyc = 0; cyc < 64 && !finished; cyc++) begin
                check("rd_rvalid", cli_rvalid, exp_rv ? oh : '0);
                if (exp_rv) check("rd_rdata", cli_rdata, exp_byte);
                check("rd_done", cli_done, (exp_rv && sent == BL) ? oh : '0);
                check("rd_rden", rden, sent != BL);
                check("rd_wren", wren, 0);
                if (sent != BL) check("rd_addr", addr, c_addr[pick]);
                if (sent == BL) begin
                    finished = 1;
                end else begin
                    if ($urandom_range(0, 2) != 0) begin
                        rd_data  = (rd_q.size() > 0) ? rd_q.pop_front() : 8'($urandom);
                        exp_byte = rd_data;
                        valid    = 1'b1;
                        sent++;
                        exp_rv   = 1;
                    end else begin
                        valid  = 1'b0;
                        exp_rv = 0;
                    end
                    if (drop_mid && sent == 1) cli_req[pick] = 1'b0;
                    if (rdy_mid && sent == 1) ram_rdy_n = 1'b1;
                    @(negedge clk);
                end
            end
            valid = 1'b0;
            check("rd_finish", finished, 1);
        end else begin
            repeat ($urandom_range(0, 3)) begin
                check("wr_wren", wren, 1);
                check("wr_data", wr_data, c_wdata[pick]);
                check("wr_done", cli_done, 0);
                @(negedge clk);
            end
            check("wr_wren_pre", wren, 1);
            check("wr_rden", rden, 0);
            fetch = 1'b1;
            @(negedge clk);
            fetch = 1'b0;
            for (int h = 1; h <= WH; h++) begin
                check("hold_wren", wren, 0);
                check("hold_data", wr_data, c_wdata[pick]);
                check("hold_done", cli_done, 0);
                @(negedge clk);
            end
            check("wr_done_pulse", cli_done, oh);
            check("wr_data_clr", wr_data, 0);
            check("wr_rvalid", cli_rvalid, 0);
        end

        // The client sees done and withdraws; re-arming models a fresh request.
        cli_req[pick] = 1'b0;
        if (mode == 1) begin
            arm(pick, $urandom_range(0, 1));
        end else if (mode == 2) begin
            for (int i = 0; i < NCLI; i++)
                if (!cli_req[i] && $urandom_range(0, 1) == 1) arm(i, $urandom_range(0, 1));
            if (cli_req == '0) arm($urandom_range(0, NCLI - 1), $urandom_range(0, 1));
        end
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        int waited;
        rst_n = 1'b0; ram_rdy_n = 1'b1; cli_req = '0;
        valid = 1'b0; fetch = 1'b0; rd_data = '0;
        for (int i = 0; i < NCLI; i++) begin
            c_addr[i] = '0; c_we[i] = 1'b0; c_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rden", rden, 0);
        check("rst_wren", wren, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wr_data, 0);
        check("rst_rvalid", cli_rvalid, 0);
        check("rst_rdata", cli_rdata, 0);
        check("rst_done", cli_done, 0);

        // Controller not ready: everyone requests, nothing may be granted.
        arm(0, 0); arm(1, 0); arm(2, 1);
        c_addr[1] = 32'h0000_1234;
        c_wdata[2] = 8'h3C;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (rden || wren) seen = 1;
        end
        check("rdy_block", seen, 0);
        ram_rdy_n = 1'b0;
        mode = 0;
        run_one(0, 0);
        check("first_owner", order_q[0], 0);
        rd_q.push_back(8'hA5);
        rd_q.push_back(8'h5A);
        run_one(0, 0);
        check("second_owner", order_q[1], 1);
        run_one(0, 0);
        check("third_owner", order_q[2], 2);

        // Continuous requests from all clients: strict rotation.
        mode = 1;
        order_q.delete();
        for (int i = 0; i < NCLI; i++) arm(i, $urandom_range(0, 1));
        repeat (9) run_one(0, 0);
        for (int j = 0; j < 9; j++) check("rr_order", order_q[j], j % NCLI);

        mode = 2;
        repeat (40) run_one($urandom_range(0, 3) == 0, 0);

        // Owner withdraws mid-read: transaction completes, no re-grant afterwards.
        mode = 0;
        cli_req = '0;
        arm(0, 0);
        run_one(1, 0);
        seen = 0;
        repeat (10) begin
            if (rden || wren || cli_done != '0) seen = 1;
            @(negedge clk);
        end
        check("no_regrant", seen, 0);

        // Controller drops readiness mid-read: finish the read, then block.
        arm(1, 0);
        run_one(0, 1);
        arm(2, 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (rden || wren) seen = 1;
        end
        check("rdy_mid_block", seen, 0);
        ram_rdy_n = 1'b0;
        run_one(0, 0);

        // Asynchronous reset in the middle of a read.
        cli_req = '0;
        arm(0, 0);
        waited = 0;
        while (!rden && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_start", rden, 1);
        valid = 1'b1;
        rd_data = 8'($urandom);
        @(negedge clk);
        valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rden", rden, 0);
        check("async_rvalid", cli_rvalid, 0);
        check("async_done", cli_done, 0);
        check("async_addr", addr, 0);
        model_ptr = 0;
        cli_req = '0;
        repeat (2) @(negedge clk);
        check("rst_hold_done", cli_done, 0);
        rst_n = 1'b1;
        arm(0, 0);
        arm(1, 0);
        order_q.delete();
        run_one(0, 0);
        check("post_rst_owner", order_q[0], 0);
        cli_req = '0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
